snn_image_loader: RTL and testbench



---
 rtl/snn_image_loader.sv | 132 +++++++++++++
 tb/tb_snn_image_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_image_loader.sv
// Assembles the spiking network's pixel vector from batches of 32-bit host words
// and issues a one-cycle start pulse plus a registered run-enable for the network clock.
module snn_image_loader #(
    parameter int unsigned NUM_PIXELS  = 784,
    parameter int unsigned WORDS       = 14,
    parameter int unsigned MAX_BATCHES = 2
) (
    input  logic                    iCLK,
    input  logic                    iRESETn,
    input  logic [32*WORDS-1:0]     iDATA,
    input  logic                    iNEXT,
    input  logic                    iFINISH,
    output logic [NUM_PIXELS-1:0]   oPIXELS,
    output logic                    oSTART,
    output logic                    oRUN_EN,
    output logic [1:0]              oBATCH,
    output logic                    oOVF
);

    localparam int unsigned BATCH_BITS = 32 * WORDS;
    localparam int unsigned OFF_W      = $clog2(BATCH_BITS);
    localparam logic [1:0]  BATCH_MAX  = 2'(MAX_BATCHES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_FIRE   = 2'd3;

    logic [1:0]            state;
    logic                  nxt_s1, nxt_s2, nxt_s3;
    logic                  fin_s1, fin_s2;
    logic [1:0]            sync_valid;
    logic                  armed;
    logic                  nxt_rise;
    logic                  pend, pend_fin;
    logic [BATCH_BITS-1:0] cap_data;
    logic                  cap_fin;
    logic [31:0]           base;
    logic [OFF_W-1:0]      off;
    logic [NUM_PIXELS-1:0] pix_next;

    // Edge detect stays disarmed until the synchronized NEXT has been seen low,
    // so a NEXT held high across reset release never produces a load.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            nxt_s1     <= 1'b0;
            nxt_s2     <= 1'b0;
            nxt_s3     <= 1'b0;
            fin_s1     <= 1'b0;
            fin_s2     <= 1'b0;
            sync_valid <= 2'b00;
            armed      <= 1'b0;
        end else begin
            nxt_s1     <= iNEXT;
            nxt_s2     <= nxt_s1;
            nxt_s3     <= nxt_s2;
            fin_s1     <= iFINISH;
            fin_s2     <= fin_s1;
            sync_valid <= {sync_valid[0], 1'b1};
            if (sync_valid[1] && !nxt_s2)
                armed <= 1'b1;
        end
    end

    assign nxt_rise = armed & nxt_s2 & ~nxt_s3;

    always_comb begin
        base     = 32'(oBATCH) * BATCH_BITS;
        pix_next = oPIXELS;
        off      = '0;
        for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
            if (i >= base && i < base + BATCH_BITS) begin
                off         = OFF_W'(i - base);
                pix_next[i] = cap_data[off];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state    <= S_IDLE;
            cap_data <= '0;
            cap_fin  <= 1'b0;
            pend     <= 1'b0;
            pend_fin <= 1'b0;
            oPIXELS  <= '0;
            oSTART   <= 1'b0;
            oRUN_EN  <= 1'b1;
            oBATCH   <= 2'd0;
            oOVF     <= 1'b0;
        end else begin
            oSTART <= 1'b0;
            // An edge seen outside IDLE is parked and served on return to IDLE.
            if (nxt_rise && state != S_IDLE) begin
                pend     <= 1'b1;
                pend_fin <= fin_s2;
            end
            case (state)
                S_IDLE: begin
                    if (pend || nxt_rise) begin
                        cap_data <= iDATA;
                        cap_fin  <= pend ? pend_fin : fin_s2;
                        pend     <= 1'b0;
                        oRUN_EN  <= 1'b0;
                        if (oBATCH == 2'd0)
                            oOVF <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (oBATCH == BATCH_MAX) begin
                        oOVF <= 1'b1;
                    end else begin
                        oPIXELS <= pix_next;
                        oBATCH  <= oBATCH + 2'd1;
                    end
                    state <= cap_fin ? S_SETTLE : S_IDLE;
                end
                S_SETTLE: begin
                    oSTART  <= 1'b1;
                    oRUN_EN <= 1'b1;
                    state   <= S_FIRE;
                end
                default: begin
                    oBATCH <= 2'd0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_image_loader.sv
// Bench for snn_image_loader: timeline model of batch loads checked every cycle,
// plus literal expectations for each directed scenario.
module tb_snn_image_loader;

    localparam int NP   = 784;
    localparam int W    = 14;
    localparam int BB   = 32 * W;
    localparam int MAXB = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [BB-1:0] data  = '0;
    logic          nxt   = 1'b0;
    logic          fin   = 1'b0;
    logic [NP-1:0] pixels;
    logic          start, run_en, ovf;
    logic [1:0]    batch;

    snn_image_loader #(
        .NUM_PIXELS (NP),
        .WORDS      (W),
        .MAX_BATCHES(MAXB)
    ) dut (
        .iCLK   (clk),
        .iRESETn(rst_n),
        .iDATA  (data),
        .iNEXT  (nxt),
        .iFINISH(fin),
        .oPIXELS(pixels),
        .oSTART (start),
        .oRUN_EN(run_en),
        .oBATCH (batch),
        .oOVF   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [BB-1:0] d;
        logic        f;
    } ev_t;

    ev_t           evq[$];
    int            cyc = 0;
    logic [NP-1:0] m_pix = '0;
    logic          m_start = 1'b0;
    logic          m_run = 1'b1;
    logic          m_ovf = 1'b0;
    int            m_batch = 0;
    int            md;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            start_cnt = 0;
    int            last_start = -1;
    int            run_low = 0;

    task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BB-1:0] rep(input logic [31:0] w);
        return {W{w}};
    endfunction

    // Model: each accepted NEXT edge E captures at E+2, writes at E+3,
    // and for a last batch pulses start at E+4 and clears the count at E+5.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pix   = '0;
            m_start = 1'b0;
            m_run   = 1'b1;
            m_ovf   = 1'b0;
            m_batch = 0;
            evq.delete();
        end else begin
            cyc++;
            if (evq.size() > 0) begin
                md = cyc - evq[0].e;
                if (md == 2) begin
                    m_run = 1'b0;
                    if (m_batch == 0) m_ovf = 1'b0;
                end else if (md == 3) begin
                    if (m_batch == MAXB) begin
                        m_ovf = 1'b1;
                    end else begin
                        for (int k = 0; k < BB; k++)
                            if (m_batch * BB + k < NP) m_pix[m_batch * BB + k] = evq[0].d[k];
                        m_batch++;
                    end
                    if (!evq[0].f) void'(evq.pop_front());
                end else if (md == 4) begin
                    m_start = 1'b1;
                    m_run   = 1'b1;
                end else if (md == 5) begin
                    m_start = 1'b0;
                    m_batch = 0;
                    void'(evq.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        check("pixels", pixels, m_pix);
        check1("start", int'(start), int'(m_start));
        check1("run_en", int'(run_en), int'(m_run));
        check1("batch", int'(batch), m_batch);
        check1("ovf", int'(ovf), int'(m_ovf));
        if (start) begin
            start_cnt++;
            last_start = cyc;
        end
        if (!run_en) run_low++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [BB-1:0] d, input logic f, input int hold, output int e);
        ev_t ev;
        data = d;
        fin  = f;
        nxt  = 1'b1;
        e    = cyc + 1;
        ev.e = e;
        ev.d = d;
        ev.f = f;
        evq.push_back(ev);
        step(hold);
        nxt = 1'b0;
        step(6);
    endtask

    initial begin
        int            e;
        int            s0;
        logic [BB-1:0] d;
        ev_t           ev;

        #0 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(5);
        check("rst_pixels", pixels, '0);
        check1("rst_run_en", int'(run_en), 1);
        check1("rst_batch", int'(batch), 0);

        // two-batch image
        s0 = start_cnt;
        send(rep(32'hFFFFFFFF), 1'b0, 3, e);
        check1("b0_batch", int'(batch), 1);
        send(rep(32'hA5A5A5A5), 1'b1, 3, e);
        check("img_lo", NP'(pixels[447:0]), NP'({BB{1'b1}}));
        check("img_hi", NP'(pixels[783:448]), NP'({42{8'hA5}}));
        check1("start_at", last_start, e + 4);
        check1("start_cnt", start_cnt - s0, 1);
        check1("img_batch", int'(batch), 0);

        // clipping: word 13 of batch 1 lies entirely beyond pixel 783
        d = '0;
        d[32*10 +: 32] = 32'h1234ABCD;
        d[32*13 +: 32] = 32'hFFFFFFFF;
        send(rep(32'h5A5A5A5A), 1'b0, 3, e);
        send(d, 1'b1, 3, e);
        check("clip_top", NP'(pixels[783:768]), NP'(16'hABCD));
        check("clip_mid", NP'(pixels[767:448]), '0);

        // overflow
        send(rep(32'h12345678), 1'b0, 3, e);
        send(rep(32'h0F0F0F0F), 1'b0, 3, e);
        send(rep(32'h33333333), 1'b0, 3, e);
        check1("ovf_flag", int'(ovf), 1);
        check1("ovf_batch", int'(batch), 2);
        check("ovf_lo", NP'(pixels[447:0]), NP'(rep(32'h12345678)));
        check("ovf_hi", NP'(pixels[783:448]), NP'({42{8'h0F}}));
        send(rep(32'hFFFF0000), 1'b1, 3, e);
        check1("ovf_sticky", int'(ovf), 1);
        check1("ovf_fire_batch", int'(batch), 0);

        // single-batch image
        run_low = 0;
        s0 = start_cnt;
        send(rep(32'hC3C3C3C3), 1'b1, 3, e);
        check1("single_ovf_clr", int'(ovf), 0);
        check1("single_run_low", run_low, 2);
        check1("single_start", start_cnt - s0, 1);
        check("single_lo", NP'(pixels[447:0]), NP'(rep(32'hC3C3C3C3)));
        check("single_hi", NP'(pixels[783:448]), NP'({42{8'h0F}}));

        // glitch pulse then held-high NEXT
        send(rep(32'h77777777), 1'b0, 1, e);
        check1("glitch_batch", int'(batch), 1);
        check("glitch_lo", NP'(pixels[447:0]), NP'(rep(32'h77777777)));
        s0 = start_cnt;
        send(rep(32'h88888888), 1'b1, 12, e);
        check1("held_start", start_cnt - s0, 1);
        check("held_hi", NP'(pixels[783:448]), NP'({42{8'h88}}));

        // reset mid-load with NEXT still high afterwards
        data = rep(32'h11111111);
        fin  = 1'b0;
        nxt  = 1'b1;
        ev.e = cyc + 1;
        ev.d = data;
        ev.f = 1'b0;
        evq.push_back(ev);
        step(3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pixels", pixels, '0);
        check1("mid_rst_run_en", int'(run_en), 1);
        check1("mid_rst_batch", int'(batch), 0);
        check1("mid_rst_start", int'(start), 0);
        step(3);
        rst_n = 1'b1;
        step(10);
        check1("held_after_rst", int'(batch), 0);
        nxt = 1'b0;
        step(3);
        send(rep(32'h99999999), 1'b1, 3, e);
        check("after_rst_lo", NP'(pixels[447:0]), NP'(rep(32'h99999999)));
        check("after_rst_hi", NP'(pixels[783:448]), '0);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
